alu_mc_pipe: RTL
================

Name: alu_mc_pipe

Overview:
- Parametrised, multi-cycle successor to the team's generated combinational ALUs.
- Same opcode map, fully defined compare ops, registered result and flags, valid/ready handshakes on input and output.
- DIV is an iterative restoring divider (one quotient bit per clock), so wide-word DIV no longer creates a huge combinational divider.
- Sits between the operand-issue stage and the writeback stage of the datapath.

Parameters:
- WIDTH, 128, operand/result width in bits; legal range 8..256, power of two.
- SHW, $clog2(WIDTH), width of shiftValue.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operation presented
- in_ready  output  1  block can accept an operation
- opcode  input  4  operation select
- input1  input  WIDTH  operand A / dividend
- input2  input  WIDTH  operand B / divisor
- shiftValue  input  SHW  shift/rotate amount
- out_valid  output  1  result, carryFlag, zeroFlag and overFlowFlag are valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  registered result
- carryFlag  output  1  registered carry flag
- zeroFlag  output  1  registered zero flag
- overFlowFlag  output  1  registered overflow flag
- busy  output  1  high in DIV_RUN

Behaviour:
- Opcodes:
  - 0 OR, 1 SGE, 2 AND, 3 SRA, 4 ROR, 5 PASSB, 6 SLT, 7 DIV, 8 NAND, 9 XOR, 10 SLTU.
  - 11 REM only when the optional feature is compiled in.
  - 12..15 (and 11 without the feature): result 0, all flags 0 except zeroFlag=1.
- Reset: state=IDLE; in_ready=1; out_valid=0; busy=0; result=0; all flags=0.
- Handshakes:
  - Accept when in_valid && in_ready. in_ready = (state==IDLE).
  - Operands, opcode and shiftValue are captured at accept; inputs are ignored otherwise.
- State machine IDLE / DIV_RUN / DONE:
  - IDLE, accept, opcode DIV/REM with input2 != 0 -> DIV_RUN, iteration counter = WIDTH-1.
  - IDLE, accept, any other op -> DONE; result and flags computed combinationally from the inputs and registered on the accept edge.
  - DIV_RUN: one restoring step per cycle (shift remainder left 1 and bring in the next dividend MSB; subtract divisor when remainder >= divisor; set quotient bit). Leave for DONE when the counter reaches 0.
  - DONE: out_valid=1; result and flags held stable until out_ready. On out_valid && out_ready -> IDLE.
- Latency:
  - Non-DIV: out_valid in the cycle after accept.
  - DIV/REM: out_valid WIDTH+1 cycles after accept.
  - Throughput: one op per 2 cycles minimum (DONE->IDLE is a mandatory cycle).
- Result semantics:
  - SGE/SLT: signed compare; SLTU: unsigned compare. Result is zero-extended 1 bit.
  - SRA: arithmetic shift of input1 by shiftValue.
  - ROR: rotate input1 right by shiftValue (modulo WIDTH).
  - DIV: unsigned quotient.
  - Divide by zero: skip DIV_RUN and go to DONE next cycle with result=0, overFlowFlag=1.
- Flags:
  - zeroFlag = (result==0) for every op.
  - carryFlag: SRA/ROR = last bit shifted/rotated out, i.e. input1[shiftValue-1]; 0 when shiftValue==0. All other ops: 0.
  - overFlowFlag: 1 only on divide-by-zero; 0 otherwise.
- Boundaries:
  - reset asserted mid-DIV_RUN or in DONE aborts the op: state to IDLE and outputs to reset values on that edge. No stale out_valid.
  - out_ready held low indefinitely: outputs stay frozen and in_ready stays 0.
  - in_valid while not in IDLE: ignored, with no side effects.

Optional Feature:
- Macro ALU_MC_REM_EN.
- Defined: opcode 11 = REM. It shares the DIV_RUN datapath and returns the unsigned remainder with the same latency. REM by zero gives result=input1 and overFlowFlag=1.
- Undefined: opcode 11 is treated as undefined (result 0, zeroFlag=1) and no remainder register is exported.

Test Plan:
- WIDTH=8: reset 3 cycles, then check in_ready=1, out_valid=0, result=0x00, flags=0.
- WIDTH=8, opcode SRA, input1=0x90, shiftValue=3 -> after 1 cycle result=0xF2, carryFlag=0. Then shiftValue=5 -> result=0xFC, carryFlag=1.
- WIDTH=8, DIV 200/7 -> out_valid exactly 9 cycles after accept, result=28, busy high for 8 cycles. With ALU_MC_REM_EN, REM 200/7 -> result=4.
- WIDTH=128, DIV input2=0 -> out_valid 1 cycle after accept, result=0, overFlowFlag=1, zeroFlag=1.
- SLT input1=-1, input2=1 -> result=1. SLTU with the same operands -> result=0, zeroFlag=1.
- Start DIV, assert reset at cycle 4 -> next cycle in_ready=1, out_valid=0. Then hold out_ready=0 for 10 cycles after an XOR -> result stable, in_ready=0 throughout.

Source files
------------

// File: rtl/alu_mc_pipe.sv
// Purpose : multi-cycle ALU. Logic/compare/shift ops are registered in one cycle; DIV (and REM) use a restoring divider.
// Latency : non-DIV ops give out_valid 1 cycle after accept; DIV/REM give it WIDTH+1 cycles after accept (divide by zero: 1 cycle).
// Backpr. : one op in flight; in_ready only in IDLE; result/flags held in DONE until out_ready.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   operation handshake; opcode, input1, input2, shiftValue sampled at accept
//   out_valid / out_ready result handshake; result, carryFlag, zeroFlag, overFlowFlag valid with out_valid
//   busy                  high while the divider iterates
//
// Optional feature: define ALU_MC_REM_EN to enable opcode 11 = unsigned REM (shares the divider).

module alu_mc_pipe #(
  parameter int WIDTH = 128,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [SHW-1:0]   shiftValue,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryFlag,
  output logic             zeroFlag,
  output logic             overFlowFlag,
  output logic             busy
);

  localparam logic [3:0] OP_OR    = 4'd0;
  localparam logic [3:0] OP_SGE   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_SRA   = 4'd3;
  localparam logic [3:0] OP_ROR   = 4'd4;
  localparam logic [3:0] OP_PASSB = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_DIV   = 4'd7;
  localparam logic [3:0] OP_NAND  = 4'd8;
  localparam logic [3:0] OP_XOR   = 4'd9;
  localparam logic [3:0] OP_SLTU  = 4'd10;
`ifdef ALU_MC_REM_EN
  localparam logic [3:0] OP_REM   = 4'd11;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIV_RUN = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t state_q, state_d;

  // output / flag registers
  logic [WIDTH-1:0] result_q;
  logic             carry_q, zero_q, ovf_q;

  // divider state: dq_q starts as the dividend and fills with quotient bits
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dq_q;
  logic [WIDTH-1:0] dvs_q;
  logic [SHW-1:0]   cnt_q;
`ifdef ALU_MC_REM_EN
  logic             rem_op_q;
`endif

  logic accept;
  logic is_div_op;
  logic div_start;

  assign accept = in_valid && in_ready;

`ifdef ALU_MC_REM_EN
  assign is_div_op = (opcode == OP_DIV) || (opcode == OP_REM);
`else
  assign is_div_op = (opcode == OP_DIV);
`endif

  // divide by zero never enters the iterative path; it is resolved by the single-cycle ALU
  assign div_start = accept && is_div_op && (input2 != '0);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (accept) begin
          state_d = div_start ? S_DIV_RUN : S_DONE;
        end
      end
      S_DIV_RUN: begin
        busy = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Single-cycle ALU (everything except a non-zero-divisor DIV/REM)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_o;
  logic [SHW-1:0]   sh_m1;
  logic             out_bit;

  // last bit shifted/rotated out is input1[shiftValue-1]; nothing leaves for a zero shift
  assign sh_m1   = shiftValue - 1'b1;
  assign out_bit = (shiftValue != '0) ? input1[sh_m1] : 1'b0;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    case (opcode)
      OP_OR:    alu_res = input1 | input2;
      OP_SGE:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(input1) >= $signed(input2))};
      OP_AND:   alu_res = input1 & input2;
      OP_SRA: begin
        alu_res = $signed(input1) >>> shiftValue;
        alu_c   = out_bit;
      end
      OP_ROR: begin
        // a zero rotate shifts left by WIDTH, which yields 0, leaving input1 intact
        alu_res = (input1 >> shiftValue) | (input1 << (WIDTH - shiftValue));
        alu_c   = out_bit;
      end
      OP_PASSB: alu_res = input2;
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
      OP_DIV: begin
        // only selected for a zero divisor
        alu_res = '0;
        alu_o   = 1'b1;
      end
      OP_NAND:  alu_res = ~(input1 & input2);
      OP_XOR:   alu_res = input1 ^ input2;
      OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (input1 < input2)};
`ifdef ALU_MC_REM_EN
      OP_REM: begin
        // only selected for a zero divisor: remainder is the dividend
        alu_res = input1;
        alu_o   = 1'b1;
      end
`endif
      default:  alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Restoring divide step
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] div_final;

  // shifted partial remainder needs one extra bit; no borrow out means remainder >= divisor
  assign trial    = {rem_q, dq_q[WIDTH-1]} - {1'b0, dvs_q};
  assign qbit     = ~trial[WIDTH];
  assign rem_next = qbit ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], dq_q[WIDTH-1]};
  assign quo_next = {dq_q[WIDTH-2:0], qbit};

`ifdef ALU_MC_REM_EN
  assign div_final = rem_op_q ? rem_next : quo_next;
`else
  assign div_final = quo_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rem_q    <= '0;
      dq_q     <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
`ifdef ALU_MC_REM_EN
      rem_op_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div_start) begin
            rem_q    <= '0;
            dq_q     <= input1;
            dvs_q    <= input2;
            cnt_q    <= SHW'(WIDTH - 1);
`ifdef ALU_MC_REM_EN
            rem_op_q <= (opcode == OP_REM);
`endif
          end else if (accept) begin
            result_q <= alu_res;
            carry_q  <= alu_c;
            zero_q   <= (alu_res == '0);
            ovf_q    <= alu_o;
          end
        end
        S_DIV_RUN: begin
          rem_q <= rem_next;
          dq_q  <= quo_next;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            result_q <= div_final;
            carry_q  <= 1'b0;
            zero_q   <= (div_final == '0);
            ovf_q    <= 1'b0;
          end
        end
        default: begin
          // DONE: everything held until the consumer takes it
        end
      endcase
    end
  end

  assign result       = result_q;
  assign carryFlag    = carry_q;
  assign zeroFlag     = zero_q;
  assign overFlowFlag = ovf_q;

endmodule
